// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller bundle: ID/EX hazard inputs and pipeline-register control outputs.
// The master side is the pipeline datapath and the slave side is pipe_hazard_ctrl.
// Optional macro HAZ_PERF_CNT_EN adds the performance counter outputs.
interface pipe_hazard_ctrl_if
`ifdef HAZ_PERF_CNT_EN
    #(parameter int CNT_W = 16)
`endif
    ;
    // hazard sources from the ID and EX stages and the data memory
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_mispredict;
    logic       mem_busy;

    // enables and flushes for PC and pipeline registers
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       redirect;
    logic [1:0] ctrl_state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] freeze_cycles;
    logic [CNT_W-1:0] redirect_count;
`endif

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, ex_mem_read, ex_mispredict, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, redirect, ctrl_state
`ifdef HAZ_PERF_CNT_EN
        , input stall_cycles, freeze_cycles, redirect_count
`endif
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, ex_mem_read, ex_mispredict, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, redirect, ctrl_state
`ifdef HAZ_PERF_CNT_EN
        , output stall_cycles, freeze_cycles, redirect_count
`endif
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline.
// Priority: memory freeze, then mispredict redirect, then the INIT/FLUSH window,
// then load-use stall, then normal run. Control outputs are combinational from
// the registered state/counter and the inputs, so they act on the same clock edge.
// The INIT/FLUSH window keeps IF/ID flushed while synchronous instruction memory
// catches up after reset release or a redirect.
// Optional macro HAZ_PERF_CNT_EN adds saturating stall/freeze/redirect counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1
`ifdef HAZ_PERF_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [2:0] CNT_INIT   = 3'(FLUSH_CYCLES);
    localparam logic [2:0] CNT_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     r_state;
    logic [2:0] r_cnt;

    state_t     w_nextState;
    logic [2:0] w_nextCnt;
    logic       w_loadUse;
    logic       w_stall;
    logic       w_pcEn;
    logic       w_ifIdEn;
    logic       w_ifIdFlush;
    logic       w_idExEn;
    logic       w_idExFlush;
    logic       w_exMemEn;
    logic       w_redirect;

    // x0 never creates a hazard; register compares are exact 5-bit matches
    assign w_loadUse = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                       ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                        (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    // prioritised control decode and next-state/next-count selection
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_pcEn      = 1'b0;
        w_ifIdEn    = 1'b0;
        w_ifIdFlush = 1'b0;
        w_idExEn    = 1'b0;
        w_idExFlush = 1'b0;
        w_exMemEn   = 1'b0;
        w_redirect  = 1'b0;
        w_stall     = 1'b0;
        if (!rst) begin
            w_ifIdFlush = 1'b1;
            w_idExFlush = 1'b1;
        end else if (bus.mem_busy) begin
            w_nextState = r_state;
            w_nextCnt   = r_cnt;
        end else if (bus.ex_mispredict) begin
            w_redirect  = 1'b1;
            w_pcEn      = 1'b1;
            w_ifIdEn    = 1'b1;
            w_idExEn    = 1'b1;
            w_exMemEn   = 1'b1;
            w_ifIdFlush = 1'b1;
            w_idExFlush = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                w_nextState = ST_FLUSH;
                w_nextCnt   = CNT_RELOAD;
            end else begin
                w_nextState = ST_RUN;
            end
        end else begin
            case (r_state)
                ST_INIT, ST_FLUSH: begin
                    w_pcEn      = 1'b1;
                    w_ifIdEn    = 1'b1;
                    w_idExEn    = 1'b1;
                    w_exMemEn   = 1'b1;
                    w_ifIdFlush = 1'b1;
                    w_idExFlush = (r_state == ST_INIT);
                    w_nextCnt   = r_cnt - 3'd1;
                    if (r_cnt <= 3'd1) begin
                        w_nextState = ST_RUN;
                        w_nextCnt   = 3'd0;
                    end
                end
                ST_RUN: begin
                    w_idExEn  = 1'b1;
                    w_exMemEn = 1'b1;
                    if (w_loadUse) begin
                        w_stall     = 1'b1;
                        w_idExFlush = 1'b1;
                    end else begin
                        w_pcEn   = 1'b1;
                        w_ifIdEn = 1'b1;
                    end
                end
                default: begin
                    w_ifIdFlush = 1'b1;
                    w_idExFlush = 1'b1;
                    w_nextState = ST_INIT;
                    w_nextCnt   = CNT_INIT;
                end
            endcase
        end
    end

    // state and flush-window counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
            r_cnt   <= CNT_INIT;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    assign bus.pc_en       = w_pcEn;
    assign bus.if_id_en    = w_ifIdEn;
    assign bus.if_id_flush = w_ifIdFlush;
    assign bus.id_ex_en    = w_idExEn;
    assign bus.id_ex_flush = w_idExFlush;
    assign bus.ex_mem_en   = w_exMemEn;
    assign bus.redirect    = w_redirect;
    assign bus.ctrl_state  = r_state;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_freezeCycles;
    logic [CNT_W-1:0] r_redirectCount;

    // saturating event counters for stalls, freezes and redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCycles   <= '0;
            r_freezeCycles  <= '0;
            r_redirectCount <= '0;
        end else begin
            if (w_stall && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (bus.mem_busy && (r_freezeCycles != '1)) begin
                r_freezeCycles <= r_freezeCycles + 1'b1;
            end
            if (w_redirect && (r_redirectCount != '1)) begin
                r_redirectCount <= r_redirectCount + 1'b1;
            end
        end
    end

    assign bus.stall_cycles   = r_stallCycles;
    assign bus.freeze_cycles  = r_freezeCycles;
    assign bus.redirect_count = r_redirectCount;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: dutA uses FLUSH_CYCLES=3, dutB uses
// FLUSH_CYCLES=1; both see identical inputs. Observed control vector layout is
// {ctrl_state[1:0], pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, redirect}.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   passCount  = 0;
    int   failCount  = 0;

    localparam logic [8:0] V_RESET     = 9'b00_0010100;
    localparam logic [8:0] V_INIT      = 9'b00_1111110;
    localparam logic [8:0] V_RUN       = 9'b01_1101010;
    localparam logic [8:0] V_STALL     = 9'b01_0001110;
    localparam logic [8:0] V_FLUSH     = 9'b10_1111010;
    localparam logic [8:0] V_MISP_RUN  = 9'b01_1111111;
    localparam logic [8:0] V_MISP_FLSH = 9'b10_1111111;
    localparam logic [8:0] V_FRZ_RUN   = 9'b01_0000000;
    localparam logic [8:0] V_FRZ_FLSH  = 9'b10_0000000;

    // free-running pipeline clock, rising edges at 5, 15, 25 ...
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if busA ();
    pipe_hazard_ctrl_if busB ();

    pipe_hazard_ctrl #(.FLUSH_CYCLES(3)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    function automatic logic [8:0] obsA();
        return {busA.ctrl_state, busA.pc_en, busA.if_id_en, busA.if_id_flush,
                busA.id_ex_en, busA.id_ex_flush, busA.ex_mem_en, busA.redirect};
    endfunction

    function automatic logic [8:0] obsB();
        return {busB.ctrl_state, busB.pc_en, busB.if_id_en, busB.if_id_flush,
                busB.id_ex_en, busB.id_ex_flush, busB.ex_mem_en, busB.redirect};
    endfunction

    task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic rs1Used, input logic rs2Used,
                                 input logic [4:0] rd, input logic memRead,
                                 input logic mispredict, input logic busy);
        busA.id_rs1 = rs1;         busB.id_rs1 = rs1;
        busA.id_rs2 = rs2;         busB.id_rs2 = rs2;
        busA.id_rs1_used = rs1Used; busB.id_rs1_used = rs1Used;
        busA.id_rs2_used = rs2Used; busB.id_rs2_used = rs2Used;
        busA.ex_rd = rd;           busB.ex_rd = rd;
        busA.ex_mem_read = memRead; busB.ex_mem_read = memRead;
        busA.ex_mispredict = mispredict; busB.ex_mispredict = mispredict;
        busA.mem_busy = busy;      busB.mem_busy = busy;
    endtask

    task automatic checkValue(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] expected);
        checkValue(tag, {7'd0, obsA()}, {7'd0, expected});
    endtask

    task automatic checkOutputB(input string tag, input logic [8:0] expected);
        checkValue(tag, {7'd0, obsB()}, {7'd0, expected});
    endtask

    // directed sequence: inputs change on falling edges, outputs sampled 1ns later
    initial begin
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        #2 rst = 1'b0;
        #1;
        checkOutput("reset_a", V_RESET);
        checkOutputB("reset_b", V_RESET);

        @(negedge clk); rst = 1'b1;
        applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("init1", V_INIT);
        checkOutputB("init1_b", V_INIT);

        @(negedge clk); applyStimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("init2_lu_suppressed", V_INIT);
        checkOutputB("b_run_stall", V_STALL);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("init3", V_INIT);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("run_after_init", V_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("lu_rs2_stall", V_STALL);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("after_stall_run", V_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("lu_x0_nostall", V_RUN);

        @(negedge clk); applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("lu_rs1_stall", V_STALL);

        @(negedge clk); applyStimulus(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("lu_rs1_unused", V_RUN);

        @(negedge clk); applyStimulus(5'd7, 5'd0, 1'b1, 1'b0, 5'd23, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("lu_bit4_differs", V_RUN);

        @(negedge clk); applyStimulus(5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("match_not_load", V_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0); #1;
        checkOutput("misp_beats_lu", V_MISP_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("flush_cnt2", V_FLUSH);
        checkOutputB("b_misp_to_run", V_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
        checkOutput("misp_in_flush", V_MISP_FLSH);

        @(negedge clk); applyStimulus(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0); #1;
        checkOutput("flush_restart_lu_supp", V_FLUSH);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("flush_last", V_FLUSH);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("run_after_flush", V_RUN);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1); #1;
            checkOutput($sformatf("freeze_misp%0d", i), V_FRZ_RUN);
        end

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
        checkOutput("misp_after_freeze", V_MISP_RUN);

        for (int i = 0; i < 2; i++) begin
            @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1); #1;
            checkOutput($sformatf("freeze_in_flush%0d", i), V_FRZ_FLSH);
        end

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("flush_held_cnt2", V_FLUSH);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("flush_held_cnt1", V_FLUSH);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("run_after_freeze", V_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0); #1;
        checkOutput("misp_last", V_MISP_RUN);

        @(negedge clk); applyStimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0); #1;
        checkOutput("flush_before_reset", V_FLUSH);
`ifdef HAZ_PERF_CNT_EN
        checkValue("stall_cycles", busA.stall_cycles, 16'd2);
        checkValue("freeze_cycles", busA.freeze_cycles, 16'd6);
        checkValue("redirect_count", busA.redirect_count, 16'd4);
`endif

        #2 rst = 1'b0;
        #1;
        checkOutput("reset_mid_flush", V_RESET);
`ifdef HAZ_PERF_CNT_EN
        checkValue("stall_cleared", busA.stall_cycles, 16'd0);
        checkValue("freeze_cleared", busA.freeze_cycles, 16'd0);
        checkValue("redirect_cleared", busA.redirect_count, 16'd0);
`endif

        @(negedge clk); rst = 1'b1; #1;
        checkOutput("reinit1", V_INIT);
        @(negedge clk); #1;
        checkOutput("reinit2", V_INIT);
        @(negedge clk); #1;
        checkOutput("reinit3", V_INIT);
        @(negedge clk); #1;
        checkOutput("rerun", V_RUN);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage RV32 pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable.
- Detects load-use hazards and branch mispredicts, and freezes the pipe while data memory is busy.
- Holds a post-reset/post-redirect flush window that covers synchronous instruction-memory latency.

Parameters:
- FLUSH_CYCLES, 1, cycles IF/ID is flushed after reset release or a redirect; legal range 1..7.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_rs1_used  in  1  ID instruction reads rs1.
- id_rs2_used  in  1  ID instruction reads rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_mispredict  in  1  EX branch/jump resolved opposite to the prediction, or to a wrong target.
- mem_busy  in  1  data memory not ready; the whole pipe must hold.
- pc_en  out  1  PC register update enable.
- if_id_en  out  1  IF/ID pipeline enable.
- if_id_flush  out  1  IF/ID flush (tags the ID slot invalid).
- id_ex_en  out  1  ID/EX pipeline enable.
- id_ex_flush  out  1  ID/EX bubble insert.
- ex_mem_en  out  1  EX/MEM pipeline enable.
- redirect  out  1  PC mux selects the EX-resolved target this cycle.
- ctrl_state  out  2  FSM state: 0=INIT, 1=RUN, 2=FLUSH.

Behaviour:
- Registered state: a 2-bit FSM and a 3-bit flush counter cnt. All control outputs are combinational from state, cnt and inputs, so they take effect at the same clock edge.
- While rst=0:
  - state=INIT, cnt=FLUSH_CYCLES.
  - pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=0, redirect=0.
  - if_id_flush=1, id_ex_flush=1.
- Priority, highest first: mem_busy, then ex_mispredict, then state INIT/FLUSH, then load-use, then normal run.
- Freeze (mem_busy=1, any state):
  - All enables 0; both flushes 0; redirect=0.
  - State and cnt hold.
  - A mispredict held in EX is taken on the first cycle after mem_busy drops.
- Mispredict (mem_busy=0, ex_mispredict=1, any state):
  - redirect=1; pc_en, if_id_en, id_ex_en and ex_mem_en all 1.
  - if_id_flush=1, id_ex_flush=1.
  - If FLUSH_CYCLES>1: next state FLUSH with cnt=FLUSH_CYCLES-1. Otherwise next state RUN.
  - A mispredict arriving while in FLUSH restarts cnt.
- INIT (no freeze, no mispredict):
  - pc_en=1, all enables 1, if_id_flush=1, id_ex_flush=1.
  - cnt decrements; at cnt==1 the next state is RUN.
  - Load-use detection is suppressed.
- FLUSH:
  - Same outputs as INIT except id_ex_flush=0 (ID is already invalid, so ID/EX receives a flushed slot).
  - cnt decrements; at cnt==1 the next state is RUN.
  - Load-use detection is suppressed.
- load_use = ex_mem_read & (ex_rd!=0) & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
- RUN with load_use=1:
  - pc_en=0, if_id_en=0, if_id_flush=0.
  - id_ex_en=1, id_ex_flush=1 (one bubble), ex_mem_en=1.
  - State stays RUN. The stall lasts exactly 1 cycle because the load advances to MEM.
- RUN, no hazard: all enables 1, all flushes 0, redirect=0.
- x0 is never a hazard source. Register compares are exact 5-bit compares.
- Reset asserted mid-stall or mid-flush returns to INIT immediately (asynchronous); no pending state survives.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: adds outputs stall_cycles[CNT_W-1:0], freeze_cycles[CNT_W-1:0] and redirect_count[CNT_W-1:0].
  - stall_cycles: +1 per load-use cycle.
  - freeze_cycles: +1 per mem_busy cycle.
  - redirect_count: +1 per redirect cycle.
  - Each counter saturates at all-ones and is cleared by rst.
- Not defined: these ports and counters do not exist; control behaviour is identical.

Test Plan:
- FLUSH_CYCLES=3; release rst -> if_id_flush=1 for 3 cycles with ctrl_state 0; then ctrl_state=1 and if_id_flush=0.
- RUN; ex_mem_read=1, ex_rd=5, id_rs2=5, id_rs2_used=1 -> exactly 1 cycle of pc_en=0, if_id_en=0, id_ex_flush=1; normal run the next cycle. Repeat with ex_rd=0 -> no stall.
- RUN; ex_mispredict=1 for 1 cycle with FLUSH_CYCLES=2 -> redirect=1 and both flushes=1 that cycle; next cycle ctrl_state=2 with if_id_flush=1 and redirect=0; then RUN.
- mem_busy=1 for 4 cycles with ex_mispredict=1 held -> all enables 0 and redirect=0 for 4 cycles; redirect=1 on the 5th cycle.
- Load-use and ex_mispredict both 1 in the same cycle -> mispredict wins: pc_en=1, redirect=1, no stall.
- HAZ_PERF_CNT_EN defined: 2 load-use stalls, 4 freeze cycles, 1 redirect -> stall_cycles=2, freeze_cycles=4, redirect_count=1. Assert rst mid-FLUSH -> ctrl_state=0 and all counters 0 immediately.
